disp_share_arbiter: RTL and testbench

//  Shares the single 4-digit seven-segment display (DispNum: HEXS/EN/P) among

---
 rtl/disp_arb_pkg.sv | 13 +
 rtl/disp_share_arbiter_rr_pick.sv | 38 +++
 rtl/disp_share_arbiter.sv | 130 +++++++++++++
 tb/tb_disp_share_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_arb_pkg.sv
// rtl/disp_arb_pkg.sv - shared state type and blank display constants for disp_share_arbiter
package disp_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, TAG} state_t;

  localparam int NREQ_MAX = 8;
  localparam int IDX_W    = 3;

  localparam logic [15:0] HEXS_BLANK = 16'h0000;
  localparam logic [3:0]  EN_BLANK   = 4'b0000;
  localparam logic [3:0]  P_BLANK    = 4'b0000;

endpackage

// File: rtl/disp_share_arbiter_rr_pick.sv
// rtl/disp_share_arbiter_rr_pick.sv - combinational round-robin pick starting after index last
module rr_pick
  import disp_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  // rot[j] is the request sitting j+1 places after last, so rot[0] has top priority
  assign dbl = {req, req} >> (int'(last) + 1);
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    int s;
    s       = 0;
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!valid && rot[j]) begin
        s = int'(last) + 1 + j;
        if (s >= NREQ) s = s - NREQ;
        valid = 1'b1;
      end
    end
    win_idx = IDX_W'(s);
    if (valid) win = NREQ'(1) << s;
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// rtl/disp_share_arbiter.sv - round-robin sharing of the seven-segment display with bounded hold
// rtl/disp_share_arbiter.sv - DISP_OWNER_TAG_EN adds a TAG phase showing the owner index on each grant change
module disp_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 100_000_000,
  parameter int TAG_HOLD = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*16-1:0] hexs_in,
  input  logic [NREQ*4-1:0] en_in,
  input  logic [NREQ*4-1:0] dp_in,
  output logic [NREQ-1:0]   grant,
  output logic [15:0]       HEXS,
  output logic [3:0]        EN,
  output logic [3:0]        P,
  output logic              busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [NREQ-1:0]    win;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic               others, owner_req, release_own, expire, change, drop;
  logic [15:0]        own_hexs;
  logic [3:0]         own_en, own_dp;

`ifdef DISP_OWNER_TAG_EN
  localparam int TAG_W = $clog2(TAG_HOLD + 1);
  logic [TAG_W-1:0]   tag_cnt;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  assign others      = |(req & ~grant);
  assign owner_req   = |(req & grant);
  assign release_own = (state != IDLE) && !owner_req;
  assign expire      = (state == OWN) && owner_req && others &&
                       (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  // last == current owner, so the pick naturally skips the owner when rotating
  assign change      = win_valid && ((state == IDLE) || release_own || expire);
  assign drop        = release_own && !others;

  always_comb begin
    own_hexs = '0;
    own_en   = '0;
    own_dp   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        own_hexs = own_hexs | hexs_in[16*k +: 16];
        own_en   = own_en   | en_in[4*k +: 4];
        own_dp   = own_dp   | dp_in[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      HEXS     <= HEXS_BLANK;
      EN       <= EN_BLANK;
      P        <= P_BLANK;
      hold_cnt <= '0;
      last     <= IDX_W'(NREQ - 1);
`ifdef DISP_OWNER_TAG_EN
      tag_cnt  <= '0;
`endif
    end else if (change) begin
      grant    <= win;
      last     <= win_idx;
      busy     <= 1'b1;
      hold_cnt <= '0;
`ifdef DISP_OWNER_TAG_EN
      state    <= TAG;
      tag_cnt  <= '0;
      HEXS     <= {12'h000, 1'b0, win_idx};
      EN       <= 4'b0001;
      P        <= 4'b0001;
`else
      // new owner's data shows one cycle after its grant
      state    <= OWN;
      HEXS     <= HEXS_BLANK;
      EN       <= EN_BLANK;
      P        <= P_BLANK;
`endif
    end else if (drop) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      HEXS     <= HEXS_BLANK;
      EN       <= EN_BLANK;
      P        <= P_BLANK;
      hold_cnt <= '0;
    end else if (state == OWN) begin
      HEXS     <= own_hexs;
      EN       <= own_en;
      P        <= own_dp;
      // reaching MAX_HOLD-1 with a waiter always preempts, so this never wraps
      hold_cnt <= others ? hold_cnt + HOLD_W'(1) : '0;
    end
`ifdef DISP_OWNER_TAG_EN
    else if (state == TAG) begin
      if (tag_cnt == TAG_W'(TAG_HOLD - 1)) begin
        state <= OWN;
        HEXS  <= own_hexs;
        EN    <= own_en;
        P     <= own_dp;
      end else begin
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// tb/tb_disp_share_arbiter.sv - self-checking bench for disp_share_arbiter (honours DISP_OWNER_TAG_EN)
module tb_disp_share_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;
  localparam int TAG_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] hexs_in;
  logic [15:0] en_in, dp_in;
  logic [3:0]  grant;
  logic [15:0] HEXS;
  logic [3:0]  EN, P;
  logic        busy;

  always #5 clk = ~clk;

  disp_share_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .TAG_HOLD(TAG_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .hexs_in(hexs_in), .en_in(en_in), .dp_in(dp_in),
    .grant(grant), .HEXS(HEXS), .EN(EN), .P(P), .busy(busy)
  );

  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 1'b0;

  logic [15:0] lh [4];
  logic [3:0]  le [4], lp [4];
  logic [15:0] exp_h;
  logic [3:0]  exp_e;

  int          m_owner, m_last, m_wait, m_tag, m_w;
  bit          m_others;
  logic [15:0] m_hexs;
  logic [3:0]  m_en, m_p;

  logic [3:0] tbl_req [6] = '{4'b1001, 4'b1000, 4'b0110, 4'b0011, 4'b0000, 4'b1111};
  int         tbl_len [6] = '{3, 2, 12, 20, 2, 10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int k = 0; k < 4; k++) begin
      lh[k] = 16'((cyc << 4) | k);
      le[k] = 4'(cyc + k + 1);
      lp[k] = 4'(cyc ^ (k * 5));
    end
    hexs_in = {lh[3], lh[2], lh[1], lh[0]};
    en_in   = {le[3], le[2], le[1], le[0]};
    dp_in   = {lp[3], lp[2], lp[1], lp[0]};
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    set_data();
  endtask

  function automatic int rr_next(input int from, input logic [3:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (from + i) % NREQ;
      if (r[k[1:0]]) return k;
    end
    return -1;
  endfunction

  task automatic m_blank();
    m_hexs = 16'h0000; m_en = 4'b0000; m_p = 4'b0000;
  endtask

  task automatic m_show();
    m_hexs = lh[m_owner]; m_en = le[m_owner]; m_p = lp[m_owner];
  endtask

  task automatic m_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_wait  = 0;
`ifdef DISP_OWNER_TAG_EN
    m_tag  = TAG_HOLD;
    m_hexs = 16'(w); m_en = 4'b0001; m_p = 4'b0001;
`else
    m_tag = 0;
    m_blank();
`endif
  endtask

  // reference model: owner index, RR pointer, cycles held while someone waits
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_last = NREQ - 1; m_wait = 0; m_tag = 0;
      m_blank();
    end else begin
      m_others = 1'b0;
      for (int j = 0; j < NREQ; j++)
        if (j != m_owner && req[j[1:0]]) m_others = 1'b1;
      if (m_owner < 0) begin
        m_w = rr_next(m_last, req);
        if (m_w >= 0) m_grant(m_w);
      end else if (!req[m_owner[1:0]]) begin
        if (m_others) m_grant(rr_next(m_last, req));
        else begin
          m_owner = -1; m_wait = 0; m_tag = 0;
          m_blank();
        end
      end else if (m_tag > 0) begin
        if (m_tag == 1) m_show();
        m_tag--;
      end else if (m_others && m_wait == MAX_HOLD - 1) begin
        m_grant(rr_next(m_last, req));
      end else begin
        m_wait = m_others ? m_wait + 1 : 0;
        m_show();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
      chk("busy", busy, m_owner >= 0);
      chk("hexs", HEXS, m_hexs);
      chk("en", EN, m_en);
      chk("p", P, m_p);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    set_data();
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", EN, 0);
    chk("rst_hexs", HEXS, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

`ifndef DISP_OWNER_TAG_EN
    req = 4'b0100;
    tick();
    chk("first_grant", grant, 4'b0100);
    chk("first_busy", busy, 1);
    exp_h = lh[2];
    exp_e = le[2];
    tick();
    chk("first_hexs", HEXS, exp_h);
    chk("first_en", EN, exp_e);
    req = 4'b0000;
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_en", EN, 0);

    req = 4'b0001; tick();
    req = 4'b0101; tick();
    chk("hold_owner0", grant, 4'b0001);
    req = 4'b0100; tick();
    chk("handoff_no_gap", grant, 4'b0100);
    chk("handoff_busy", busy, 1);
    req = 4'b0000; tick();
    chk("drop_grant", grant, 0);
    chk("drop_en", EN, 0);

    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int n = 0; n < 5 * MAX_HOLD; n++) begin
      tick();
      chk("rr_grant", grant, 1 << ((n / MAX_HOLD) % NREQ));
    end
    req = 4'b0000; tick();

    req = 4'b0010;
    for (int n = 0; n < 5 * MAX_HOLD; n++) begin
      tick();
      chk("sole_grant", grant, 4'b0010);
    end
    req = 4'b0011;
    for (int n = 1; n <= MAX_HOLD; n++) begin
      tick();
      chk("sole_then_wait", grant, (n < MAX_HOLD) ? 4'b0010 : 4'b0001);
    end

    req = 4'b0100; tick(); tick();
    req = 4'b1110; tick();
    chk("pre_async_owner", grant, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_busy", busy, 0);
    chk("async_en", EN, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("restart_lowest", grant, 4'b0010);
`else
    req = 4'b1000;
    tick();
    for (int n = 0; n < TAG_HOLD; n++) begin
      chk("tag_grant", grant, 4'b1000);
      chk("tag_hexs", HEXS, 16'h0003);
      chk("tag_en", EN, 4'b0001);
      exp_h = lh[3];
      tick();
    end
    chk("tag_then_data", HEXS, exp_h);
`endif

    for (int v = 0; v < 6; v++) begin
      req = tbl_req[v];
      repeat (tbl_len[v]) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
